// File: rtl/fact_seq.sv
// Bus-master sequencer for the factorial accelerator: takes a job over a request handshake,
// runs the n/go/status/result register cycles and returns the result. Optional: FACT_SEQ_PERF_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | ready for a job, bus quiet
//   WR_N     | writing operand to addr 0
//   WR_GO    | writing go=1 to addr 1
//   WR_GOCLR | writing go=0 to addr 1
//   WAIT     | settle, status ignored so a stale done is skipped
//   POLL     | sampling status {err,done} at addr 2
//   RD_RES   | reading result at addr 3
//   RESP     | holding response until consumer accepts

module fact_seq #(
   parameter int TIMEOUT     = 255,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [3:0]  req_n,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_nf,
   output logic        resp_err,
   output logic        resp_timeout,
   input  logic        resp_ready,
   output logic [1:0]  fa,
   output logic        fwe,
   output logic [3:0]  fwd,
   input  logic [31:0] frd
`ifdef FACT_SEQ_PERF_EN
   ,
   output logic [15:0] resp_cycles
`endif
);

   localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam int WW = $clog2(WAIT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, WR_N, WR_GO, WR_GOCLR, WAIT, POLL, RD_RES, RESP
   } state_t;

   state_t          state;
   logic [TW-1:0]   to_cnt;
   logic [WW-1:0]   wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_nf      <= '0;
         resp_err     <= 1'b0;
         resp_timeout <= 1'b0;
         fa           <= 2'd0;
         fwe          <= 1'b0;
         fwd          <= 4'd0;
         to_cnt       <= '0;
         wait_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  state     <= WR_N;
                  fa        <= 2'd0;
                  fwe       <= 1'b1;
                  fwd       <= req_n;
                  to_cnt    <= '0;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WR_N: begin
               state <= WR_GO;
               fa    <= 2'd1;
               fwe   <= 1'b1;
               fwd   <= 4'b0001;
            end
            WR_GO: begin
               state <= WR_GOCLR;
               fa    <= 2'd1;
               fwe   <= 1'b1;
               fwd   <= 4'd0;
            end
            WR_GOCLR: begin
               state    <= WAIT;
               fa       <= 2'd2;
               fwe      <= 1'b0;
               fwd      <= 4'd0;
               wait_cnt <= WAIT_LOAD;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= POLL;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            POLL: begin
               // err takes priority over done when both are reported
               if (frd[1]) begin
                  resp_err   <= 1'b1;
                  resp_nf    <= '0;
                  resp_valid <= 1'b1;
                  fa         <= 2'd0;
                  state      <= RESP;
               end else if (frd[0]) begin
                  fa    <= 2'd3;
                  state <= RD_RES;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (to_cnt == TO_LAST) begin
                     resp_err     <= 1'b1;
                     resp_timeout <= 1'b1;
                     resp_nf      <= '0;
                     resp_valid   <= 1'b1;
                     fa           <= 2'd0;
                     state        <= RESP;
                  end
               end
            end
            RD_RES: begin
               resp_nf    <= frd;
               resp_valid <= 1'b1;
               fa         <= 2'd0;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid   <= 1'b0;
                  resp_err     <= 1'b0;
                  resp_timeout <= 1'b0;
                  req_ready    <= 1'b1;
                  to_cnt       <= '0;
                  wait_cnt     <= '0;
                  state        <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               fwe       <= 1'b0;
            end
         endcase
      end
   end

`ifdef FACT_SEQ_PERF_EN
   logic [15:0] cyc_cnt;

   // the accept cycle itself counts as the first cycle of the job
   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_cnt <= '0;
      end else if (state == IDLE && req_valid && req_ready) begin
         cyc_cnt <= 16'd1;
      end else if (state != IDLE && state != RESP && cyc_cnt != 16'hFFFF) begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

   assign resp_cycles = cyc_cnt;
`endif

endmodule

// File: tb/tb_fact_seq.sv
// Directed bench for fact_seq with a behavioural accelerator slave whose status
// behaviour (normal, err, err+done, stuck, stale done) is selected per job.

module tb_fact_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [3:0]  req_n = 4'd0;
   logic        resp_ready = 1'b0;
   logic        req_ready, resp_valid, resp_err, resp_timeout, fwe;
   logic [31:0] resp_nf, frd;
   logic [1:0]  fa;
   logic [3:0]  fwd;
`ifdef FACT_SEQ_PERF_EN
   logic [15:0] resp_cycles;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 0;
   int cyc;

   always #5 clk = ~clk;

   fact_seq #(.TIMEOUT(8), .WAIT_CYCLES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_n        (req_n),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_nf      (resp_nf),
      .resp_err     (resp_err),
      .resp_timeout (resp_timeout),
      .resp_ready   (resp_ready),
      .fa           (fa),
      .fwe          (fwe),
      .fwd          (fwd),
      .frd          (frd)
`ifdef FACT_SEQ_PERF_EN
      ,
      .resp_cycles  (resp_cycles)
`endif
   );

   // slave: mode 0 normal, 1 err, 2 err+done, 3 stuck, 4 stale done kept through WAIT
   logic [3:0]  s_n;
   logic        s_go, s_done, s_err;
   logic [31:0] s_res;
   int          s_cnt;
   logic [5:0]  wlog[$];

   function automatic logic [31:0] fact(input logic [3:0] n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
      return r;
   endfunction

   always_comb begin
      case (fa)
         2'd0:    frd = {28'd0, s_n};
         2'd1:    frd = {31'd0, s_go};
         2'd2:    frd = {30'd0, s_err, s_done};
         default: frd = s_res;
      endcase
   end

   always @(posedge clk) begin
      if (!rst) begin
         s_n <= 4'd0; s_go <= 1'b0; s_done <= 1'b0; s_err <= 1'b0;
         s_res <= 32'd0; s_cnt <= 0;
      end else begin
         if (fwe && fa == 2'd0) s_n <= fwd;
         if (fwe && fa == 2'd1) s_go <= fwd[0];
         if (fwe && fa == 2'd1 && fwd[0]) begin
            s_cnt  <= 5;
            s_err  <= (mode == 1 || mode == 2);
            s_done <= (mode == 2 || mode == 4);
         end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 3 && mode == 4) s_done <= 1'b0;
            if (s_cnt == 1 && (mode == 0 || mode == 4)) begin
               s_done <= 1'b1;
               s_res  <= fact(s_n);
            end
         end
      end
   end

   always @(posedge clk) if (rst && fwe) wlog.push_back({fa, fwd});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] n);
      int k;
      k = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_before_send", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_n     = n;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int c);
      c = 0;
      while (resp_valid !== 1'b1 && c < 60) begin
         @(negedge clk);
         c++;
      end
      chk("resp_arrives", 32'(resp_valid), 32'd1);
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("ack_valid_low", 32'(resp_valid), 32'd0);
      chk("ack_ready_high", 32'(req_ready), 32'd1);
   endtask

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_nf", resp_nf, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
      chk("rst_fa", 32'(fa), 32'd0);
      chk("rst_fwe", 32'(fwe), 32'd0);
      chk("rst_fwd", 32'(fwd), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("release_req_ready", 32'(req_ready), 32'd1);

      // n=3: bus cycles, result, latency
      mode = 0;
      wlog.delete();
      send(4'd3);
      wait_resp(cyc);
      chk("n3_latency", 32'(cyc), 32'd9);
      chk("n3_nf", resp_nf, 32'd6);
      chk("n3_err", 32'(resp_err), 32'd0);
      chk("n3_timeout", 32'(resp_timeout), 32'd0);
      chk("n3_write_count", 32'(wlog.size()), 32'd3);
      if (wlog.size() == 3) begin
         chk("n3_write0", 32'(wlog[0]), 32'h03);
         chk("n3_write1", 32'(wlog[1]), 32'h11);
         chk("n3_write2", 32'(wlog[2]), 32'h10);
      end
      ack();

      // n=0
      send(4'd0);
      wait_resp(cyc);
      chk("n0_nf", resp_nf, 32'd1);
      chk("n0_err", 32'(resp_err), 32'd0);
      ack();

      // stale done from the previous job must be skipped
      mode = 4;
      send(4'd4);
      wait_resp(cyc);
      chk("stale_latency", 32'(cyc), 32'd9);
      chk("stale_nf", resp_nf, 32'd24);
      chk("stale_err", 32'(resp_err), 32'd0);
      ack();

      // back-pressure, with a request pending through the handshake
      mode = 0;
      send(4'd5);
      wait_resp(cyc);
      req_valid = 1'b1;
      req_n     = 4'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_nf", resp_nf, 32'd120);
         chk("bp_err", 32'(resp_err), 32'd0);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("bp_hs_valid_low", 32'(resp_valid), 32'd0);
      chk("bp_hs_no_accept", 32'(fwe), 32'd0);
      chk("bp_hs_ready", 32'(req_ready), 32'd1);

      // err on first poll
      mode = 1;
      send(4'd6);
      wait_resp(cyc);
      chk("err_latency", 32'(cyc), 32'd6);
      chk("err_err", 32'(resp_err), 32'd1);
      chk("err_timeout", 32'(resp_timeout), 32'd0);
      chk("err_nf", resp_nf, 32'd0);
      ack();

      // err and done together: err wins
      mode = 2;
      send(4'd6);
      wait_resp(cyc);
      chk("errdone_err", 32'(resp_err), 32'd1);
      chk("errdone_timeout", 32'(resp_timeout), 32'd0);
      chk("errdone_nf", resp_nf, 32'd0);
      ack();

      // timeout after 8 polls
      mode = 3;
      send(4'd2);
      wait_resp(cyc);
      chk("tmo_latency", 32'(cyc), 32'd13);
      chk("tmo_err", 32'(resp_err), 32'd1);
      chk("tmo_timeout", 32'(resp_timeout), 32'd1);
      chk("tmo_nf", resp_nf, 32'd0);
      ack();

      // n=12 after a timeout
      mode = 0;
      send(4'd12);
      wait_resp(cyc);
      chk("n12_latency", 32'(cyc), 32'd9);
      chk("n12_nf", resp_nf, 32'd479001600);
      chk("n12_timeout", 32'(resp_timeout), 32'd0);
      ack();

      // reset during POLL
      wlog.delete();
      send(4'd7);
      repeat (5) @(negedge clk);
      chk("mid_in_poll_fa", 32'(fa), 32'd2);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_fwe", 32'(fwe), 32'd0);
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_fa", 32'(fa), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_release_ready", 32'(req_ready), 32'd1);
      chk("mid_no_more_writes", 32'(wlog.size()), 32'd3);

      // recovery job
      send(4'd1);
      wait_resp(cyc);
      chk("rec_latency", 32'(cyc), 32'd9);
      chk("rec_nf", resp_nf, 32'd1);
      ack();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
